// File: rtl/vec_div_arb.sv
// Round-robin arbiter/sequencer sharing one vec_div datapath among N_REQ requesters.
// Issues one start per grant, returns captured quotient/flags, aborts stalled transactions.
module vec_div_arb #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned ARR_WIDTH = 8,
    parameter int unsigned FXP_N     = 16,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [N_REQ-1:0]                            req,
    input  logic [N_REQ-1:0][ARR_WIDTH-1:0][FXP_N-1:0]  req_in_1,
    input  logic [N_REQ-1:0][ARR_WIDTH-1:0][FXP_N-1:0]  req_in_2,
    output logic [N_REQ-1:0]                            gnt,
    output logic [N_REQ-1:0]                            rsp_valid,
    output logic [ARR_WIDTH-1:0][FXP_N-1:0]             rsp_out,
    output logic                                        rsp_dbz,
    output logic                                        rsp_ovf,
    output logic                                        rsp_err,
    output logic                                        busy,
    output logic                                        div_start,
    output logic [ARR_WIDTH-1:0][FXP_N-1:0]             div_in_1,
    output logic [ARR_WIDTH-1:0][FXP_N-1:0]             div_in_2,
    input  logic                                        div_busy,
    input  logic                                        div_done,
    input  logic [ARR_WIDTH-1:0][FXP_N-1:0]             div_out,
    input  logic                                        div_dbz,
    input  logic                                        div_ovf
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StResp, StDrain} state_e;

    state_e                          state_q, state_d;
    logic [IDX_W-1:0]                ptr_q, ptr_d;
    logic [IDX_W-1:0]                gnt_idx_q, gnt_idx_d;
    logic [TMR_W-1:0]                timer_q, timer_d;
    logic                            timeout_q, timeout_d;
    logic [ARR_WIDTH-1:0][FXP_N-1:0] rsp_out_q, rsp_out_d;
    logic                            rsp_dbz_q, rsp_dbz_d;
    logic                            rsp_ovf_q, rsp_ovf_d;
    logic                            rsp_err_q, rsp_err_d;

    logic                            arb_found;
    logic [IDX_W-1:0]                arb_idx;
    logic [IDX_W-1:0]                arb_nxt;

    // Cyclic first-set scan starting at ptr.
    always_comb begin
        int unsigned cand;
        cand      = 0;
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = (32'(ptr_q) + i) % N_REQ;
            if (!arb_found && req[cand[IDX_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[IDX_W-1:0];
            end
        end
        arb_nxt = IDX_W'((32'(arb_idx) + 32'd1) % N_REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            gnt_idx_q <= '0;
            timer_q   <= '0;
            timeout_q <= 1'b0;
            rsp_out_q <= '0;
            rsp_dbz_q <= 1'b0;
            rsp_ovf_q <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_idx_q <= gnt_idx_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
            rsp_out_q <= rsp_out_d;
            rsp_dbz_q <= rsp_dbz_d;
            rsp_ovf_q <= rsp_ovf_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_idx_d = gnt_idx_q;
        timer_d   = timer_q;
        timeout_d = timeout_q;
        rsp_out_d = rsp_out_q;
        rsp_dbz_d = rsp_dbz_q;
        rsp_ovf_d = rsp_ovf_q;
        rsp_err_d = rsp_err_q;
        unique case (state_q)
            StIdle: begin
                if (arb_found && !div_busy) begin
                    gnt_idx_d = arb_idx;
                    ptr_d     = arb_nxt;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                timer_d   = '0;
                timeout_d = 1'b0;
                state_d   = StWait;
            end
            StWait: begin
                if (div_done) begin
                    rsp_out_d = div_out;
                    rsp_dbz_d = div_dbz;
                    rsp_ovf_d = div_ovf;
                    rsp_err_d = 1'b0;
                    state_d   = StResp;
                end else if (timeout_q) begin
                    rsp_out_d = '0;
                    rsp_dbz_d = 1'b0;
                    rsp_ovf_d = 1'b0;
                    rsp_err_d = 1'b1;
                    state_d   = StResp;
                end else begin
                    // Expiry is registered so the abort response lands TIMEOUT+2 after start.
                    if (timer_q == TMR_W'(TIMEOUT - 1)) timeout_d = 1'b1;
                    timer_d = timer_q + 1'b1;
                end
            end
            StResp: begin
                state_d = rsp_err_q ? StDrain : StIdle;
            end
            StDrain: begin
                if (!div_busy) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = (state_q != StIdle);
        div_start = (state_q == StIssue);
        gnt       = '0;
        rsp_valid = '0;
        if (state_q == StIssue || state_q == StWait || state_q == StResp) begin
            gnt = N_REQ'(1) << gnt_idx_q;
        end
        if (state_q == StResp) begin
            rsp_valid = N_REQ'(1) << gnt_idx_q;
        end
    end

    assign div_in_1 = req_in_1[gnt_idx_q];
    assign div_in_2 = req_in_2[gnt_idx_q];
    assign rsp_out  = rsp_out_q;
    assign rsp_dbz  = rsp_dbz_q;
    assign rsp_ovf  = rsp_ovf_q;
    assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_vec_div_arb.sv
// Directed self-checking bench for vec_div_arb with a 3-cycle Q8.8 divider stub.
module tb_vec_div_arb;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 8;
    localparam int unsigned FW = 16;
    localparam int unsigned TO = 10;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic [N-1:0]                  req = '0;
    logic [N-1:0][AW-1:0][FW-1:0]  req_in_1;
    logic [N-1:0][AW-1:0][FW-1:0]  req_in_2;
    logic [N-1:0]                  gnt, rsp_valid;
    logic [AW-1:0][FW-1:0]         rsp_out, div_in_1, div_in_2;
    logic                          rsp_dbz, rsp_ovf, rsp_err, busy, div_start;
    logic                          div_busy = 1'b0;
    logic                          div_done = 1'b0;
    logic [AW-1:0][FW-1:0]         div_out = '0;
    logic                          div_dbz = 1'b0;
    logic                          div_ovf = 1'b0;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    bit hang = 1'b0;

    always #5 clk = ~clk;

    vec_div_arb #(.N_REQ(N), .ARR_WIDTH(AW), .FXP_N(FW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_in_1(req_in_1), .req_in_2(req_in_2),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_out(rsp_out), .rsp_dbz(rsp_dbz),
        .rsp_ovf(rsp_ovf), .rsp_err(rsp_err), .busy(busy), .div_start(div_start),
        .div_in_1(div_in_1), .div_in_2(div_in_2), .div_busy(div_busy),
        .div_done(div_done), .div_out(div_out), .div_dbz(div_dbz), .div_ovf(div_ovf)
    );

    // Divider stub: Q8.8 lane divide, done 4 cycles after start; 'hang' freezes it.
    logic [AW-1:0][FW-1:0] a_q, b_q, q_c;
    logic                  dbz_c, ovf_c;
    logic [2:0]            sc = '0;

    always_comb begin
        logic [31:0] t;
        t     = '0;
        q_c   = '0;
        dbz_c = 1'b0;
        ovf_c = 1'b0;
        for (int l = 0; l < AW; l++) begin
            if (b_q[l] == '0) begin
                dbz_c = 1'b1;
            end else begin
                t      = ({16'h0, a_q[l]} << 8) / {16'h0, b_q[l]};
                q_c[l] = t[15:0];
                if (t[31:16] != '0) ovf_c = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        div_done <= 1'b0;
        if (div_start) start_cnt <= start_cnt + 1;
        if (rst) begin
            div_busy <= 1'b0;
            sc       <= '0;
        end else if (div_start) begin
            div_busy <= 1'b1;
            sc       <= 3'd3;
            a_q      <= div_in_1;
            b_q      <= div_in_2;
        end else if (sc != '0 && !hang) begin
            sc <= sc - 3'd1;
            if (sc == 3'd1) begin
                div_busy <= 1'b0;
                div_done <= 1'b1;
                div_out  <= q_c;
                div_dbz  <= dbz_c;
                div_ovf  <= ovf_c;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start();
        bit got = 1'b0;
        for (int n = 0; n < 30 && !got; n++) begin
            @(negedge clk);
            got = div_start;
        end
        chk("start_seen", 128'(got), 128'(1));
    endtask

    // Waits for rsp_valid, returns cycles counted from the div_start cycle.
    task automatic wait_rsp(output int cyc);
        bit got = 1'b0;
        cyc = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            cyc++;
            got = |rsp_valid;
        end
        chk("rsp_seen", 128'(got), 128'(1));
    endtask

    task automatic serve(input logic [N-1:0] exp_gnt, input bit drop);
        int cyc;
        wait_start();
        chk("gnt", 128'(gnt), 128'(exp_gnt));
        wait_rsp(cyc);
        chk("rsp_latency", 128'(cyc), 128'(5));
        chk("rsp_valid", 128'(rsp_valid), 128'(exp_gnt));
        if (drop) req = req & ~exp_gnt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int cyc;
        int s0;
        bit seen;
        for (int r = 0; r < N; r++) begin
            for (int l = 0; l < AW; l++) begin
                req_in_1[r][l] = 16'h0600;
                req_in_2[r][l] = 16'h0200;
            end
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_outputs", 128'({gnt, rsp_valid, busy, div_start}), 128'(0));
        chk("rst_rsp", rsp_out, '0);
        chk("rst_flags", 128'({rsp_dbz, rsp_ovf, rsp_err}), 128'(0));
        rst = 1'b0;
        @(negedge clk);

        // Single request: 6.0 / 2.0 = 3.0 in every lane
        req = 4'b0001;
        @(negedge clk);
        chk("single_start", 128'({div_start, busy, gnt}), 128'({1'b1, 1'b1, 4'b0001}));
        wait_rsp(cyc);
        chk("single_latency", 128'(cyc), 128'(5));
        chk("single_valid", 128'(rsp_valid), 128'(4'b0001));
        chk("single_out", rsp_out, {8{16'h0300}});
        chk("single_flags", 128'({rsp_dbz, rsp_ovf, rsp_err}), 128'(0));
        req = '0;
        @(negedge clk);
        chk("single_pulse", 128'({rsp_valid, gnt}), 128'(0));

        // Simultaneous 1010 from reset: 1 then 3
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        s0  = start_cnt;
        req = 4'b1010;
        serve(4'b0010, 1'b1);
        serve(4'b1000, 1'b1);
        repeat (3) @(negedge clk);
        chk("pair_starts", 128'(start_cnt - s0), 128'(2));

        // Continuous requests from all four: strict rotation
        req = 4'b1111;
        for (int i = 0; i < 8; i++) serve(4'(1 << (i % 4)), 1'b0);
        req = '0;

        // Divide by zero on lane 2, lane 5 = 1.0/4.0
        req_in_2[2][2] = 16'h0000;
        req_in_1[2][5] = 16'h0100;
        req_in_2[2][5] = 16'h0400;
        req = 4'b0100;
        serve(4'b0100, 1'b1);
        chk("dbz_out", rsp_out, {16'h0300, 16'h0300, 16'h0040, 16'h0300,
                                 16'h0300, 16'h0000, 16'h0300, 16'h0300});
        chk("dbz_flags", 128'({rsp_dbz, rsp_ovf, rsp_err}), 128'(3'b100));

        // Overflow on lane 7: 64.0 / (1/16) does not fit
        req_in_1[3][7] = 16'h4000;
        req_in_2[3][7] = 16'h0010;
        req = 4'b1000;
        serve(4'b1000, 1'b1);
        chk("ovf_out", rsp_out, {16'h0000, {7{16'h0300}}});
        chk("ovf_flags", 128'({rsp_dbz, rsp_ovf, rsp_err}), 128'(3'b010));

        // Timeout with hung divider, then DRAIN until busy drops
        hang = 1'b1;
        req  = 4'b0001;
        wait_start();
        chk("to_gnt", 128'(gnt), 128'(4'b0001));
        wait_rsp(cyc);
        chk("to_latency", 128'(cyc), 128'(TO + 2));
        chk("to_valid", 128'(rsp_valid), 128'(4'b0001));
        chk("to_flags", 128'({rsp_dbz, rsp_ovf, rsp_err}), 128'(3'b001));
        chk("to_out", rsp_out, '0);
        req = 4'b0010;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (!busy || gnt != '0 || div_start || rsp_valid != '0) seen = 1'b1;
        end
        chk("drain_hold", 128'(seen), 128'(0));
        hang = 1'b0;
        serve(4'b0010, 1'b1);
        chk("post_drain_out", rsp_out, {8{16'h0300}});
        chk("post_drain_flags", 128'({rsp_dbz, rsp_ovf, rsp_err}), 128'(0));

        // Reset mid-WAIT
        req = 4'b0100;
        wait_start();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        chk("midrst_outputs", 128'({gnt, rsp_valid, busy, div_start}), 128'(0));
        chk("midrst_rsp", rsp_out, '0);
        chk("midrst_flags", 128'({rsp_dbz, rsp_ovf, rsp_err}), 128'(0));
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid != '0 || busy) seen = 1'b1;
        end
        chk("midrst_quiet", 128'(seen), 128'(0));
        req = 4'b1001;
        serve(4'b0001, 1'b1);
        chk("midrst_out", rsp_out, {8{16'h0300}});
        serve(4'b1000, 1'b1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
